// File: rtl/weight_loader.sv
// Streams K weights per filter from weight memory into up to NUM_PE weight buffers,
// one filter per buffer, waiting on each buffer's ready before moving to the next.
module weight_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_PE     = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            kernel_size,
  input  logic [7:0]            num_filters,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [NUM_PE-1:0]     flush,
  output logic [DATA_WIDTH-1:0] flush_data,
  input  logic [NUM_PE-1:0]     flush_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int         FW     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [7:0] PE_MAX = 8'(NUM_PE);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_RDY, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [7:0]            k;
    logic [7:0]            nf;
  } cfg_t;

  state_t        state;
  cfg_t          cfg;
  logic [FW-1:0] f;
  logic [7:0]    i;
  logic          vld_d;

  // Offset is formed 16 bits wide so f*K cannot overflow before the address wraps.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] b,
    input logic [7:0]            k,
    input logic [FW-1:0]         fi,
    input logic [7:0]            ii
  );
    logic [15:0] off;
    off = 16'(fi) * 16'(k) + 16'(ii);
    return b + ADDR_WIDTH'(off);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cfg       <= '0;
      f         <= '0;
      i         <= '0;
      vld_d     <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
    end else begin
      vld_d <= mem_rd_en;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (kernel_size == 8'd0 || num_filters == 8'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cfg       <= '{base_addr, kernel_size,
                           (num_filters > PE_MAX) ? PE_MAX : num_filters};
            f         <= '0;
            i         <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
            state     <= READ;
          end
        end
        READ: begin
          if (i == cfg.k - 8'd1) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            i        <= i + 8'd1;
            mem_addr <= word_addr(cfg.base, cfg.k, f, i + 8'd1);
          end
        end
        DRAIN: state <= WAIT_RDY;
        // Only the buffer currently being filled is allowed to release the wait.
        WAIT_RDY: if (flush_ready[f]) begin
          if (8'(f) == cfg.nf - 8'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            f         <= f + 1'b1;
            i         <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= word_addr(cfg.base, cfg.k, f + 1'b1, 8'd0);
            state     <= READ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    assign flush[p] = vld_d && (f == FW'(p));
  end

  assign flush_data = mem_rd_data;
  assign busy       = (state != IDLE);

endmodule
